// File: rtl/hsv_core_pkg.sv
// Shared types and constants for the hsv core memory unit.
package hsv_core_pkg;

  // Width of the outstanding-transaction counters (mem_counter and response tracking).
  localparam int unsigned MEM_CNT_W = 4;

  // Number of buffered responses awaiting writeback.
  localparam int unsigned MEM_RESP_DEPTH = 4;

  // One bus response as seen by writeback.
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } mem_response;

endpackage

// File: rtl/hsv_core_mem_response_fifo.sv
// Synchronous FIFO of mem_response entries with a synchronous clear.
// The read port shows the head entry and holds the last shown value when empty.
module hsv_core_mem_response_fifo
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_RESP_DEPTH
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  mem_response wdata,
  output mem_response rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  mem_response           mem_q [DEPTH];
  mem_response           mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  mem_response           last_q, last_d;

  logic do_push;
  logic do_pop;

  // Status flags and head read; empty shows the last value that was on the port.
  always_comb begin
    full    = (count_q == CntW'(DEPTH));
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rdata   = empty ? last_q : mem_q[rd_ptr_q];
  end

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      last_d   = rdata;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        last_d   = rdata;
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/hsv_core_mem_response.sv
// Response side of the memory unit: buffers in-order bus responses for writeback,
// pulses resp_done per delivered response, and drops responses of flushed requests.
module hsv_core_mem_response
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_RESP_DEPTH,
  parameter int unsigned CNT_W = MEM_CNT_W
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        req_issued,
  input  logic        flush,
  output logic        can_issue,
  input  logic        bus_rvalid,
  output logic        bus_rready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rerr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output logic        resp_done
);

  localparam logic [CNT_W-1:0] InflightMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        bus_fire;
  logic        discarding;
  mem_response bus_resp;
  mem_response head;

  // Handshake glue; bus_rready depends on registers only.
  always_comb begin
    discarding = (discard_q != '0);
    can_issue  = (inflight_q != InflightMax);
    bus_rready = discarding | ~fifo_full;
    bus_fire   = bus_rvalid & bus_rready;
    out_valid  = ~fifo_empty;
    fifo_pop   = out_valid & out_ready;
    // Responses accepted during a flush belong to flushed requests.
    fifo_push  = bus_fire & ~discarding & ~flush;
    resp_done  = fifo_pop & ~flush;
    bus_resp   = '{data: bus_rdata, err: bus_rerr};
    out_data   = head.data;
    out_err    = head.err;
  end

  // In-flight tracks real bus transactions; discard counts responses still owed to flushed requests.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(req_issued) - CNT_W'(bus_fire);
    discard_d  = discard_q;
    if (flush) begin
      // A request issued in the flush cycle is post-flush and is not discarded.
      discard_d = inflight_q - CNT_W'(bus_fire);
    end else if (discarding && bus_fire) begin
      discard_d = discard_q - CNT_W'(1);
    end
  end

  // Counter registers with asynchronous reset.
  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  hsv_core_mem_response_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_core(clk_core),
    .rst_core(rst_core),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (flush),
    .wdata   (bus_resp),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Issuing with the counter saturated would wrap the in-flight count.
  assert property (@(posedge clk_core) disable iff (rst_core) !(req_issued && !can_issue))
    else $error("req_issued while can_issue is low");

endmodule

// File: doc/hsv_core_mem_response.md
Name: hsv_core_mem_response

Overview:
- Response-side companion to the memory unit's outstanding-transaction counter.
- Accepts in-order read/write responses from the data bus and buffers them for writeback.
- Emits the per-response `resp_done` pulse that decrements the counter.
- Tracks bus transactions still in flight across a pipeline flush, so that responses belonging to flushed requests are drained and dropped instead of reaching writeback.

Parameters:
DEPTH, 4, response FIFO entries (power of two, >=2)
CNT_W, 4, width of in-flight and discard counters; max in-flight = 2**CNT_W-1

Ports:
clk_core  in  1  core clock, all state on rising edge
rst_core  in  1  asynchronous, active-high reset
req_issued  in  1  pulse: one bus request accepted this cycle
flush  in  1  pulse: discard all older transactions
can_issue  out  1  high when in-flight count < 2**CNT_W-1
bus_rvalid  in  1  bus response valid
bus_rready  out  1  bus response ready
bus_rdata  in  32  response data (zero for writes)
bus_rerr  in  1  bus error on response
out_valid  out  1  buffered response valid to writeback
out_ready  in  1  writeback ready
out_data  out  32  head entry data
out_err  out  1  head entry error
resp_done  out  1  pulse: one response delivered (counter "down")

Behaviour:
- Reset values (async on rst_core):
  - inflight=0, discard=0, FIFO empty.
  - out_valid=0, out_data=0, out_err=0, resp_done=0.
  - can_issue=1, bus_rready=1.
- bus_fire = bus_rvalid & bus_rready; out_fire = out_valid & out_ready.
- inflight counter:
  - +1 on req_issued, -1 on bus_fire; both in the same cycle leaves it unchanged.
  - Never cleared by flush; it tracks real bus transactions.
  - can_issue = (inflight != 2**CNT_W-1), combinational from the register.
  - req_issued while can_issue=0 is illegal; covered by an assertion, no wrap.
- discard counter:
  - On flush: discard <= inflight - bus_fire.
    - Responses accepted in the flush cycle are consumed.
    - req_issued in the flush cycle is a post-flush request and is not discarded.
  - Otherwise, if discard != 0 and bus_fire: discard - 1; the response is dropped, never written to the FIFO.
- bus_rready = (discard != 0) | ~fifo_full.
  - Combinational from registers only; no path from out_ready or bus_rvalid.
  - While discarding, responses are accepted unconditionally.
- FIFO:
  - Push when bus_fire & discard==0 & ~flush.
  - Pop on out_fire.
  - When full, a same-cycle pop does not open bus_rready; no bypass.
- Latency: bus_fire in cycle N -> out_valid in cycle N+1 at the earliest. Strict in-order delivery.
- out_valid = ~fifo_empty. out_data/out_err always reflect the head entry; they hold the last value when empty.
- flush:
  - Empties the FIFO: pointers and count reset, out_valid=0 from the next cycle.
  - Entries pushed in the flush cycle are not retained.
- resp_done = out_fire & ~flush, combinational, one pulse per delivered response. Dropped responses never pulse.
- Full/empty: count register of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Reset mid-operation: all state cleared immediately (async). Bus responses arriving afterwards are treated as new; bus and issuer are reset together.

Decomposition:
- hsv_core_pkg gains:
  - typedef mem_response (struct: logic [31:0] data, logic err)
  - constant MEM_RESP_DEPTH=4
- mem_counter width and CNT_W share one package constant.
- One sub-module: hsv_core_mem_response_fifo, a synchronous FIFO of mem_response with push, pop, clear, full, empty.
- The top holds the inflight/discard counters and the handshake glue.

Test Plan:
- Reset: assert rst_core mid-traffic -> out_valid=0, resp_done=0, bus_rready=1, can_issue=1, inflight=0, discard=0 on the same edge.
- In-order path: 3 req_issued, then responses 0x11, 0x22, 0x33 back-to-back, out_ready=1 -> out_data 0x11, 0x22, 0x33 each one cycle after its bus_fire; 3 resp_done pulses; inflight=0.
- Backpressure: out_ready=0, 5 responses (DEPTH=4) -> bus_rready=0 after the 4th push; raise out_ready -> all 5 delivered in order with 5 resp_done pulses.
- Flush drain: 3 in flight plus 1 entry buffered, pulse flush -> out_valid=0 next cycle; next 3 bus responses accepted with bus_rready=1 and dropped, no resp_done; a 4th request issued post-flush returns 0xAB and is delivered.
- Flush collision: inflight=2 with flush, bus_fire and req_issued in one cycle -> discard=1, inflight=2; the next response is dropped and the following one is delivered.
- Saturation: 15 req_issued with no responses (CNT_W=4) -> can_issue=0; one bus_fire -> can_issue=1.
